// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing widths and the packed per-pixel timing/colour bundle
package vga_pkg;

  localparam int HCOUNT_W  = 11;
  localparam int VCOUNT_W  = 11;
  localparam int RGB_W     = 12;
  localparam int DELAY_MIN = 1;
  localparam int DELAY_MAX = 16;
  localparam int CH_MIN    = 1;
  localparam int CH_MAX    = 8;

  // One pipeline stage carries the whole bundle as a single vector so no field can skip a stage.
  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
    logic [RGB_W-1:0]    rgb;
  } vga_sig_t;

  localparam int VGA_SIG_W = $bits(vga_sig_t);

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing/colour interface shared between draw stages
interface vga_if;
  import vga_pkg::*;

  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic                hsync;
  logic                vsync;
  logic                hblnk;
  logic                vblnk;
  logic [RGB_W-1:0]    rgb;

  modport source (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport sink   (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/delay_reg.sv
// rtl/delay_reg.sv - generic DELAY-deep shift register with synchronous active-low reset
module delay_reg #(
  parameter int W     = 1,
  parameter int DELAY = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DELAY];
  logic [W-1:0] stage_d [DELAY];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DELAY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DELAY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DELAY-1];

endmodule

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - DELAY-clock retiming of vga_if plus aligned sideband words and primed flag
// VGA_DELAY_FRAME_LATCH_EN: sideband is latched on the vblnk rising edge instead of delayed.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int DELAY = 1,
  parameter int CH    = 2,
  parameter int W     = 12
) (
  input  logic         clk40MHz,
  input  logic         rst,
  vga_if.sink          in_if,
  vga_if.source        out_if,
  input  logic [W-1:0] side_in  [CH],
  output logic [W-1:0] side_out [CH],
  output logic         primed
);

  if (DELAY < DELAY_MIN || DELAY > DELAY_MAX) begin : g_bad_delay
    $error("vga_delay_line: DELAY must be in 1..16");
  end
  if (CH < CH_MIN || CH > CH_MAX) begin : g_bad_ch
    $error("vga_delay_line: CH must be in 1..8");
  end

  localparam int              CNT_W    = $clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DELAY);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;

  // primed is derived from the next count so it rises on the same edge the first sample emerges.
  always_comb begin
    cnt_d    = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
    primed_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk40MHz) begin
    if (!rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  assign primed = primed_q;

  vga_sig_t in_sig, out_sig;

  assign in_sig = {in_if.hcount, in_if.vcount, in_if.hsync, in_if.vsync,
                   in_if.hblnk, in_if.vblnk, in_if.rgb};

  delay_reg #(
    .W     (VGA_SIG_W),
    .DELAY (DELAY)
  ) u_vga_dly (
    .clk    (clk40MHz),
    .resetn (rst),
    .din    (in_sig),
    .dout   (out_sig)
  );

  assign out_if.hcount = out_sig.hcount;
  assign out_if.vcount = out_sig.vcount;
  assign out_if.hsync  = out_sig.hsync;
  assign out_if.vsync  = out_sig.vsync;
  assign out_if.hblnk  = out_sig.hblnk;
  assign out_if.vblnk  = out_sig.vblnk;
  assign out_if.rgb    = out_sig.rgb;

`ifdef VGA_DELAY_FRAME_LATCH_EN
  logic         vblnk_q, vblnk_d;
  logic [W-1:0] hold_q [CH];
  logic [W-1:0] hold_d [CH];

  // Capture only on the undelayed vblnk rising edge so side_out never changes mid-frame.
  always_comb begin
    vblnk_d = in_if.vblnk;
    hold_d  = hold_q;
    if (in_if.vblnk && !vblnk_q) begin
      hold_d = side_in;
    end
  end

  always_ff @(posedge clk40MHz) begin
    if (!rst) begin
      vblnk_q <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      vblnk_q <= vblnk_d;
      hold_q  <= hold_d;
    end
  end

  assign side_out = hold_q;
`else
  for (genvar g = 0; g < CH; g++) begin : g_side
    delay_reg #(
      .W     (W),
      .DELAY (DELAY)
    ) u_side_dly (
      .clk    (clk40MHz),
      .resetn (rst),
      .din    (side_in[g]),
      .dout   (side_out[g])
    );
  end
`endif

endmodule

// File: tb/tb_vga_delay_line.sv
// tb/tb_vga_delay_line.sv - directed checks of vga_delay_line at DELAY 1, 3 and 16
module tb_vga_delay_line;
  import vga_pkg::*;

  logic clk40MHz = 1'b0;
  always #5 clk40MHz = ~clk40MHz;

  logic rst;
  vga_if in_vif ();
  vga_if o1 ();
  vga_if o3 ();
  vga_if o16 ();

  logic [11:0] side_in  [2];
  logic [11:0] side_o1  [2];
  logic [11:0] side_o3  [2];
  logic [11:0] side_o16 [2];
  logic        primed1, primed3, primed16;

  vga_delay_line #(.DELAY(1), .CH(2), .W(12)) u_dut1 (
    .clk40MHz (clk40MHz), .rst (rst), .in_if (in_vif), .out_if (o1),
    .side_in (side_in), .side_out (side_o1), .primed (primed1));
  vga_delay_line #(.DELAY(3), .CH(2), .W(12)) u_dut3 (
    .clk40MHz (clk40MHz), .rst (rst), .in_if (in_vif), .out_if (o3),
    .side_in (side_in), .side_out (side_o3), .primed (primed3));
  vga_delay_line #(.DELAY(16), .CH(2), .W(12)) u_dut16 (
    .clk40MHz (clk40MHz), .rst (rst), .in_if (in_vif), .out_if (o16),
    .side_in (side_in), .side_out (side_o16), .primed (primed16));

  vga_sig_t q1, q3, q16;
  assign q1  = {o1.hcount, o1.vcount, o1.hsync, o1.vsync, o1.hblnk, o1.vblnk, o1.rgb};
  assign q3  = {o3.hcount, o3.vcount, o3.hsync, o3.vsync, o3.hblnk, o3.vblnk, o3.rgb};
  assign q16 = {o16.hcount, o16.vcount, o16.hsync, o16.vsync, o16.hblnk, o16.vblnk, o16.rgb};

  int n_checks = 0;
  int n_fail   = 0;

  vga_sig_t    hist  [0:2047];
  logic [11:0] hside [0:2047][2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input vga_sig_t s);
    in_vif.hcount = s.hcount;
    in_vif.vcount = s.vcount;
    in_vif.hsync  = s.hsync;
    in_vif.vsync  = s.vsync;
    in_vif.hblnk  = s.hblnk;
    in_vif.vblnk  = s.vblnk;
    in_vif.rgb    = s.rgb;
  endtask

  task automatic tick();
    @(posedge clk40MHz);
    #1;
  endtask

  function automatic int expc(input int n, input int d);
    return (n >= d) ? n - d : 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_q1"}, 64'(q1), 64'(0));
    check_eq({tag, "_q3"}, 64'(q3), 64'(0));
    check_eq({tag, "_q16"}, 64'(q16), 64'(0));
    check_eq({tag, "_pr1"}, 64'(primed1), 64'(0));
    check_eq({tag, "_pr3"}, 64'(primed3), 64'(0));
    check_eq({tag, "_pr16"}, 64'(primed16), 64'(0));
    check_eq({tag, "_side1"}, 64'({side_o1[0], side_o1[1]}), 64'(0));
    check_eq({tag, "_side3"}, 64'({side_o3[0], side_o3[1]}), 64'(0));
    check_eq({tag, "_side16"}, 64'({side_o16[0], side_o16[1]}), 64'(0));
  endtask

  // Edge n after release samples hcount = n-1; a DELAY-d copy shows n-d once n >= d.
  task automatic run_count(input string tag, input int nmax);
    vga_sig_t s;
    for (int n = 1; n <= nmax; n++) begin
      s = '0;
      s.hcount = 11'(n - 1);
      drive(s);
      tick();
      check_eq({tag, "_hc1"}, 64'(q1.hcount), 64'(expc(n, 1)));
      check_eq({tag, "_hc3"}, 64'(q3.hcount), 64'(expc(n, 3)));
      check_eq({tag, "_hc16"}, 64'(q16.hcount), 64'(expc(n, 16)));
      check_eq({tag, "_pr1"}, 64'(primed1), 64'(n >= 1));
      check_eq({tag, "_pr3"}, 64'(primed3), 64'(n >= 3));
      check_eq({tag, "_pr16"}, 64'(primed16), 64'(n >= 16));
    end
  endtask

  initial begin
    vga_sig_t    s;
    logic [63:0] r;
    vga_sig_t    e;

    rst = 1'b0;
    drive('0);
    side_in[0] = '0;
    side_in[1] = '0;
    repeat (2) tick();

    // Reset wins over data present on the same edge.
    drive(vga_sig_t'(38'h3F_FFFF_FFFF));
    side_in[0] = 12'hFFF;
    side_in[1] = 12'hABC;
    tick();
    check_all_zero("reset");
    side_in[0] = '0;
    side_in[1] = '0;

    rst = 1'b1;
    run_count("fill", 20);

    s = '0;
    s.hcount = 11'd500;
    s.rgb    = 12'hF0F;
    drive(s);
    rst = 1'b0;
    tick();
    check_all_zero("midrst");
    rst = 1'b1;
    run_count("refill", 20);

`ifndef VGA_DELAY_FRAME_LATCH_EN
    s = '0;
    s.hsync = 1'b1;
    drive(s);
    side_in[0] = 12'h155;
    side_in[1] = 12'h2AA;
    tick();
    check_eq("sb1_w0", 64'(side_o1[0]), 64'(12'h155));
    check_eq("sb1_w1", 64'(side_o1[1]), 64'(12'h2AA));
    check_eq("sb1_hsync", 64'(o1.hsync), 64'(1));
    check_eq("sb3_early", 64'({side_o3[0], side_o3[1]}), 64'(0));
    drive('0);
    side_in[0] = '0;
    side_in[1] = '0;
    tick();
    check_eq("sb1_gone", 64'({side_o1[0], side_o1[1]}), 64'(0));
    check_eq("sb1_hsync_gone", 64'(o1.hsync), 64'(0));
    tick();
    check_eq("sb3_w0", 64'(side_o3[0]), 64'(12'h155));
    check_eq("sb3_w1", 64'(side_o3[1]), 64'(12'h2AA));
    check_eq("sb3_hsync", 64'(o3.hsync), 64'(1));
`else
    drive('0);
    for (int i = 0; i < 6; i++) begin
      side_in[0] = 12'($urandom);
      side_in[1] = 12'($urandom);
      tick();
      check_eq("fl_pre3", 64'({side_o3[0], side_o3[1]}), 64'(0));
    end
    s = '0;
    s.vblnk = 1'b1;
    drive(s);
    side_in[0] = 12'h155;
    side_in[1] = 12'h2AA;
    tick();
    check_eq("fl_cap1", 64'({side_o1[0], side_o1[1]}), 64'({12'h155, 12'h2AA}));
    check_eq("fl_cap16", 64'({side_o16[0], side_o16[1]}), 64'({12'h155, 12'h2AA}));
    for (int i = 0; i < 12; i++) begin
      s.vblnk = (i < 4);
      drive(s);
      side_in[0] = 12'($urandom);
      side_in[1] = 12'($urandom);
      tick();
      check_eq("fl_hold3", 64'({side_o3[0], side_o3[1]}), 64'({12'h155, 12'h2AA}));
    end
    s.vblnk = 1'b1;
    drive(s);
    side_in[0] = 12'h0AB;
    side_in[1] = 12'hCDE;
    tick();
    check_eq("fl_recap3", 64'({side_o3[0], side_o3[1]}), 64'({12'h0AB, 12'hCDE}));
`endif

    // Random scoreboard from a clean reset: after edge n a DELAY-d output holds sample n-d+1.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int n = 1; n <= 1500; n++) begin
      r = {$urandom, $urandom};
      s = vga_sig_t'(r[VGA_SIG_W-1:0]);
      hist[n]     = s;
      hside[n][0] = 12'($urandom);
      hside[n][1] = 12'($urandom);
      drive(s);
      side_in[0] = hside[n][0];
      side_in[1] = hside[n][1];
      tick();
      e = (n >= 16) ? hist[n-15] : '0;
      check_eq("rnd_q16", 64'(q16), 64'(e));
      check_eq("rnd_pr16", 64'(primed16), 64'(n >= 16));
      e = (n >= 3) ? hist[n-2] : '0;
      check_eq("rnd_q3", 64'(q3), 64'(e));
      check_eq("rnd_q1", 64'(q1), 64'(hist[n]));
`ifndef VGA_DELAY_FRAME_LATCH_EN
      check_eq("rnd_side16", 64'({side_o16[0], side_o16[1]}),
               (n >= 16) ? 64'({hside[n-15][0], hside[n-15][1]}) : 64'(0));
      check_eq("rnd_side1", 64'({side_o1[0], side_o1[1]}), 64'({hside[n][0], hside[n][1]}));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
